// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

  typedef enum logic {ST_CLEAR, ST_RUN} st_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NREGS    = 32;
  localparam int DEF_NRD      = 3;
  localparam int DEF_NWR      = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

  // Address width for a given entry count; at least one bit.
  function automatic int calc_aw(input int nregs);
    return (nregs < 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// One read port: stored word, optionally overridden by same-cycle write data,
// with the zero-register override and forced-zero output while clearing.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AW       = 5,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic [AW-1:0]         raddr,
  input  logic [DATA_W-1:0]     stored,
  input  logic                  run,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]     rdata
);

  always_comb begin
    rdata = stored;
    if (BYPASS != 0) begin
      // Ascending scan: the highest matching write port is assigned last.
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (waddr[j*AW +: AW] == raddr)) rdata = wdata[j*DATA_W +: DATA_W];
      end
    end
    if ((ZERO_REG != 0) && (raddr == '0)) rdata = '0;
    if (!run) rdata = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with highest-port-wins writes, zero register,
// write-to-read bypass and a sequential one-entry-per-cycle hardware clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = DEF_NRD,
  parameter int NWR      = DEF_NWR,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic                  clr_req,
  output logic                  ready,
  output st_e                   dbg_state
);

  // Handshake: there is none beyond ready. Writes are honoured only on edges
  // where ready=1 and clr_req=0; while ready=0 all writes are dropped and
  // every read port returns 0.

  st_e             state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NREGS - 1)) begin
          state_d   = ST_RUN;
          clr_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Storage has no reset; the clear sequence defines its contents.
  always_ff @(posedge CLK) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (!clr_req) begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0)))
          mem[waddr[j*AW +: AW]] <= wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  assign ready     = (state_q == ST_RUN);
  assign dbg_state = state_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_bypass #(
      .DATA_W  (DATA_W),
      .AW      (AW),
      .NWR     (NWR),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_byp (
      .raddr (raddr[i*AW +: AW]),
      .stored(mem[raddr[i*AW +: AW]]),
      .run   (ready),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .rdata (rdata[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, hand sequences
// for reset/clear timing, and random traffic against a behavioural model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NRD = 3;
  localparam int NWR = 2;
  localparam int AW = 5;

  logic              CLK = 1'b0;
  logic              RSTN = 1'b0;
  logic [NRD*AW-1:0] raddr = '0;
  logic [NRD*DW-1:0] rdata;
  logic [NWR-1:0]    we = '0;
  logic [NWR*AW-1:0] waddr = '0;
  logic [NWR*DW-1:0] wdata = '0;
  logic              clr_req = 1'b0;
  logic              ready;
  st_e               dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  regfile_mp dut (
    .CLK(CLK), .RSTN(RSTN), .raddr(raddr), .rdata(rdata), .we(we),
    .waddr(waddr), .wdata(wdata), .clr_req(clr_req), .ready(ready),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [NR];
  bit            ref_run;
  int            ref_left;

  function automatic void ref_reset();
    ref_run  = 1'b0;
    ref_left = NR;
    for (int k = 0; k < NR; k++) ref_mem[k] = '0;
  endfunction

  function automatic logic [DW-1:0] ref_read(input int a);
    logic [DW-1:0] v;
    if (!ref_run || a == 0) return '0;
    v = ref_mem[a];
    for (int j = 0; j < NWR; j++)
      if (we[j] && int'(waddr[j*AW +: AW]) == a) v = wdata[j*DW +: DW];
    return v;
  endfunction

  function automatic void ref_edge();
    if (!RSTN) begin
      ref_reset();
    end else if (!ref_run) begin
      ref_left--;
      if (ref_left == 0) ref_run = 1'b1;
    end else if (clr_req) begin
      ref_reset();
    end else begin
      for (int j = 0; j < NWR; j++)
        if (we[j] && waddr[j*AW +: AW] != 0) ref_mem[waddr[j*AW +: AW]] = wdata[j*DW +: DW];
    end
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("ready", {31'b0, ready}, {31'b0, ref_run});
    for (int i = 0; i < NRD; i++)
      check($sformatf("rdata%0d", i), rdata[i*DW +: DW], ref_read(int'(raddr[i*AW +: AW])));
  endtask

  // Inputs are set before calling; outputs checked mid-cycle, then one edge.
  task automatic step();
    @(negedge CLK);
    check_model();
    @(posedge CLK);
    ref_edge();
    #1;
  endtask

  task automatic set_rd_all(input logic [AW-1:0] a);
    raddr = {a, a, a};
  endtask

  task automatic idle();
    we = '0; clr_req = 1'b0;
  endtask

  // Steps until ready, counting edges; expected count is exp_edges.
  task automatic wait_ready(input string name, input int exp_edges);
    int n = 0;
    while (!ready && n < 200) begin
      step();
      n++;
    end
    check(name, n, exp_edges);
  endtask

  typedef struct {
    logic [1:0]    w_en;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 5'd5, 32'hDEADBEEF};
    tbl[1] = '{2'b00, 5'd5, 5'd0, 32'h0,        32'h0, 5'd5, 32'hDEADBEEF};
    tbl[2] = '{2'b11, 5'd7, 5'd7, 32'h11,       32'h22, 5'd7, 32'h22};
    tbl[3] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 5'd7, 32'h22};
    tbl[4] = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 32'h0};
    tbl[5] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 5'd0, 32'h0};
    tbl[6] = '{2'b10, 5'd0, 5'd9, 32'h0,        32'h99, 5'd3, 32'h0};
    tbl[7] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0, 5'd9, 32'h99};

    // Reset and clear
    ref_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_rdata0", rdata[DW-1:0], 32'h0);
    RSTN = 1'b1;
    wait_ready("reset_clear_len", NR);
    for (int a = 0; a < NR; a++) begin
      set_rd_all(AW'(a));
      step();
    end

    // Directed vector table
    for (int t = 0; t < 8; t++) begin
      we = tbl[t].w_en;
      waddr = {tbl[t].wa1, tbl[t].wa0};
      wdata = {tbl[t].wd1, tbl[t].wd0};
      set_rd_all(tbl[t].ra);
      @(negedge CLK);
      for (int i = 0; i < NRD; i++) check($sformatf("tbl%0d_p%0d", t, i), rdata[i*DW +: DW], tbl[t].exp);
      step();
    end
    idle();

    // Clear request: fill 1..31 with own index, then clear
    for (int a = 1; a < NR; a += 2) begin
      we = (a + 1 < NR) ? 2'b11 : 2'b01;
      waddr = {AW'(a + 1), AW'(a)};
      wdata = {DW'(a + 1), DW'(a)};
      step();
    end
    idle();
    for (int a = 0; a < NR; a++) begin
      set_rd_all(AW'(a));
      @(negedge CLK);
      check("fill_rd", rdata[DW-1:0], DW'(a));
      step();
    end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("clr_ready_low", {31'b0, ready}, 32'h0);
    we = 2'b01; waddr = {AW'(0), AW'(3)}; wdata = {32'h0, 32'hAAAA5555};
    step();
    idle();
    wait_ready("clr_len", NR - 1);
    for (int a = 0; a < NR; a++) begin
      set_rd_all(AW'(a));
      @(negedge CLK);
      check("post_clr_rd", rdata[DW-1:0], 32'h0);
      step();
    end

    // Reset mid-clear at clr_cnt=10
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    RSTN = 1'b0;
    ref_reset();
    #1;
    check("midclr_ready", {31'b0, ready}, 32'h0);
    repeat (2) step();
    RSTN = 1'b1;
    wait_ready("midclr_len", NR);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      we = 2'($urandom_range(0, 3));
      waddr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      wdata = {$urandom, $urandom};
      raddr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      clr_req = ($urandom_range(0, 60) == 0);
      step();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
